// File: rtl/stream_distributor_pkg.sv
// Shared stream types: buffer fill level and
// the round-robin index width helper.
package stream_distributor_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } fill_e;

  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_distributor_buffer2.sv
// stream_buffer2: two-entry registered FIFO
// with valid/ready on both sides.
module stream_buffer2
  import stream_distributor_pkg::*;
#(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  input  T     in_data_i,
  input  logic in_valid_i,
  output logic in_ready_o,
  output T     out_data_o,
  output logic out_valid_o,
  input  logic out_ready_i
);

  fill_e r_state;
  T      r_head;
  T      r_tail;
  logic  w_push;
  logic  w_pop;

  assign in_ready_o  = (r_state != FULL) && !flush_i;
  assign out_valid_o = (r_state != EMPTY);
  assign out_data_o  = r_head;
  assign w_push      = in_valid_i && in_ready_o;
  assign w_pop       = out_valid_o && out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_state <= EMPTY;
    end else begin
      case (r_state)
        EMPTY: if (w_push) r_state <= ONE;
        ONE: begin
          if (w_push && !w_pop) r_state <= FULL;
          else if (w_pop && !w_push) r_state <= EMPTY;
        end
        FULL: if (w_pop) r_state <= ONE;
        default: r_state <= EMPTY;
      endcase
    end
  end

  // Payload storage is don't-care while empty.
  always_ff @(posedge clk_i) begin
    case (r_state)
      EMPTY: if (w_push) r_head <= in_data_i;
      ONE: begin
        if (w_push && w_pop) r_head <= in_data_i;
        else if (w_push) r_tail <= in_data_i;
      end
      FULL: if (w_pop) r_head <= r_tail;
      default: ;
    endcase
  end

endmodule

// File: rtl/stream_distributor.sv
// Round-robin distributor: each input beat goes
// to exactly one output, in order 0..N_OUP-1.
module stream_distributor
  import stream_distributor_pkg::*;
#(
  parameter type DATA_T = logic,
  parameter int  N_OUP  = 3
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  flush_i,
  input  DATA_T inp_data_i,
  input  logic  inp_valid_i,
  output logic  inp_ready_o,
  output DATA_T oup_data_o  [N_OUP],
  output logic  oup_valid_o [N_OUP],
  input  logic  oup_ready_i [N_OUP]
);

  localparam int IW = idx_w(N_OUP);

  typedef struct packed {
    DATA_T         data;
    logic [IW-1:0] dest;
  } entry_t;

  logic [IW-1:0] r_rr;
  entry_t        w_in;
  entry_t        w_head;
  logic          w_head_vld;
  logic          w_push;
  logic          w_pop;

  assign w_in.data = inp_data_i;
  assign w_in.dest = r_rr;
  assign w_push    = inp_valid_i && inp_ready_o;

  stream_buffer2 #(
    .T(entry_t)
  ) u_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .in_data_i   (w_in),
    .in_valid_i  (inp_valid_i),
    .in_ready_o  (inp_ready_o),
    .out_data_o  (w_head),
    .out_valid_o (w_head_vld),
    .out_ready_i (w_pop)
  );

  // Explicit wrap keeps non-power-of-two counts in range.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_rr <= '0;
    end else if (w_push) begin
      r_rr <= (r_rr == IW'(N_OUP - 1)) ? '0 : r_rr + 1'b1;
    end
  end

  always_comb begin
    w_pop = 1'b0;
    for (int k = 0; k < N_OUP; k++) begin
      oup_data_o[k]  = w_head.data;
      oup_valid_o[k] = w_head_vld && (w_head.dest == IW'(k));
      w_pop = w_pop | (oup_valid_o[k] & oup_ready_i[k]);
    end
  end

endmodule

// File: doc/stream_distributor.md
STREAM_DISTRIBUTOR -- requirements
Module: stream_distributor

Interface
REQ-001 SHALL have parameter DATA_T, default logic: payload type, broadcast unchanged to every output.
REQ-002 SHALL have parameter N_OUP, default 3: number of output streams; legal range >= 2, not required to be a power of two.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port flush_i, input, 1 bit: synchronous discard of all buffered beats.
REQ-006 SHALL have port inp_data_i, input, DATA_T: input payload.
REQ-007 SHALL have port inp_valid_i, input, 1 bit: input valid.
REQ-008 SHALL have port inp_ready_o, output, 1 bit: input ready.
REQ-009 SHALL have port oup_data_o, output, DATA_T [N_OUP]: per-output payload, all equal to the head entry.
REQ-010 SHALL have port oup_valid_o, output, 1 bit [N_OUP]: per-output valid, one-hot or all-zero.
REQ-011 SHALL have port oup_ready_i, input, 1 bit [N_OUP]: per-output ready.

Function
REQ-012 SHALL distribute successive input beats round-robin to outputs 0,1,...,N_OUP-1,0,...
REQ-013 SHALL hold the round-robin pointer rr_q in the range 0..N_OUP-1 and assign dest = rr_q at each input handshake (inp_valid_i && inp_ready_o).
REQ-014 SHALL advance rr_q on each input handshake to rr_q+1, wrapping explicitly from N_OUP-1 to 0, never through a power-of-two overflow.
REQ-015 SHALL buffer up to two entries {data, dest} in FIFO order; fill-level states are EMPTY, ONE and FULL.
REQ-016 SHALL use these state transitions: push only -> level+1; pop only -> level-1; push and pop in ONE -> stay ONE, with the new entry becoming head.
REQ-017 SHALL drive inp_ready_o = (state != FULL) && !flush_i; no push is possible in FULL and no pop in EMPTY.
REQ-018 SHALL drive oup_valid_o[head.dest] = 1 whenever state != EMPTY and all other bits 0; oup_valid_o SHALL depend only on registered state, never on oup_ready_i.
REQ-019 SHALL pop the head when oup_valid_o[k] && oup_ready_i[k]; readies of non-targeted outputs SHALL be ignored.
REQ-020 SHALL hold head data and dest invariant from valid assertion until the output handshake, with no re-targeting to a ready output.
REQ-021 SHALL present a beat accepted in cycle t as valid no earlier than cycle t+1, and SHALL sustain one beat per cycle when targets are ready.
REQ-022 SHALL, when flush_i = 1: clear the state to EMPTY and rr_q to 0 at the next edge, discard any input beat, and count an output handshake in that cycle as delivered.

Reset
REQ-023 SHALL, while rst_i = 1 at a clock edge, set state to EMPTY and rr_q to 0, giving oup_valid_o = 0 and inp_ready_o = 1 from the following cycle.
REQ-024 SHALL give rst_i priority over flush_i and all handshakes; beats held at reset mid-operation are lost.
REQ-025 SHALL treat oup_data_o as don't-care while the corresponding valid is 0, with no reset value needed on data storage.

Structure
REQ-026 SHALL take the fill-level enum (EMPTY/ONE/FULL) from the shared stream package.
REQ-027 SHALL derive the index width as max(1,$clog2(N_OUP)) in the same shared stream package.
REQ-028 SHALL be built around one sub-module, stream_buffer2 (two-entry registered buffer with valid/ready on both sides), with round-robin and dest decode in the top level.

Verification
REQ-029 SHALL check, with N_OUP = 3, 8-bit data and all readies high, that inputs 0xA0..0xA5 on consecutive cycles exit on outputs 0,1,2,0,1,2 at cycles t+1..t+6 with inp_ready_o constantly high.
REQ-030 SHALL check, with oup_ready_i[1] = 0, that 0xB0 goes to out0, 0xB1 stalls on out1, 0xB2 buffers, state is FULL and inp_ready_o = 0; on releasing ready[1], 0xB1 and then 0xB2 (out2) exit in order.
REQ-031 SHALL check, with N_OUP = 5, 7 beats, that rr_q wraps 4->0 and dests are 0,1,2,3,4,0,1.
REQ-032 SHALL check that oup_valid_o[2] stays high and oup_data_o stays 0xC3 for 4 stalled cycles while oup_ready_i[0,1] toggle, and that nothing pops.
REQ-033 SHALL check that flush_i in FULL plus a simultaneous inp_valid_i gives EMPTY next cycle, the input beat dropped, and the next beat going to out0.
REQ-034 SHALL check that rst_i asserted mid-stream with 2 beats buffered gives oup_valid_o = 0 next cycle, after which the first new beat goes to out0.
